// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Brief    : Stall/flush sequencer for a 5-stage pipeline with divide FSM,
//             stall-cycle counter and hang watchdog.
//  Revision : 1.0
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int DIV_LAT = 32,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             icache_stall,
    input  logic             dcache_stall,
    input  logic             ex_div_valid,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_branch_taken,
    output logic             stall_pc,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             stall_w,
    output logic             flush_d,
    output logic             flush_e,
    output logic             div_done,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             hang_err
);

    localparam int c_DIV_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;
    localparam int c_WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [c_DIV_W-1:0] c_DIV_LOAD = c_DIV_W'(DIV_LAT - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_ZERO = '0;
    localparam logic [c_DIV_W-1:0] c_DIV_ONE  = c_DIV_W'(1);
    localparam logic [c_WD_W-1:0]  c_WD_LAST  = c_WD_W'(TIMEOUT - 1);
    localparam logic [c_WD_W-1:0]  c_WD_MAX   = c_WD_W'(TIMEOUT);
    localparam logic [c_WD_W-1:0]  c_WD_ONE   = c_WD_W'(1);
    localparam logic [CNT_W-1:0]   c_CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_RUN = 2'd0,
        S_DIV = 2'd1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_DIV_W-1:0]  r_cnt;
    logic [c_DIV_W-1:0]  w_cnt_nxt;
    logic                w_div_freeze;
    logic                w_div_done;
    logic                w_cache_stall;
    logic                w_freeze;
    logic                w_rs1_hit;
    logic                w_rs2_hit;
    logic                w_load_use;
    logic                w_lu_act;
    logic                w_lost;
    logic [CNT_W-1:0]    r_stall_cycles;
    logic [c_WD_W-1:0]   r_wd;
    logic                r_hang;

    // ------------------------------------------------------------------
    // Divide sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_RUN;
            r_cnt   <= c_DIV_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_div_freeze = 1'b0;
        w_div_done   = 1'b0;
        case (r_state)
            S_RUN: begin
                if (ex_div_valid) begin
                    w_div_freeze = 1'b1;
                    w_state_nxt  = S_DIV;
                    w_cnt_nxt    = c_DIV_LOAD;
                end
            end
            S_DIV: begin
                if (r_cnt != c_DIV_ZERO) begin
                    w_div_freeze = 1'b1;
                    w_cnt_nxt    = r_cnt - c_DIV_ONE;
                end else begin
                    // Result stays presented until the cache lets the pipe move.
                    w_div_done = 1'b1;
                    if (!w_cache_stall) begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            default: begin
                w_state_nxt = S_RUN;
                w_cnt_nxt   = c_DIV_ZERO;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Hazard resolution: freeze > branch > load-use
    // ------------------------------------------------------------------
    assign w_cache_stall = icache_stall | dcache_stall;
    assign w_freeze      = w_cache_stall | w_div_freeze;

    assign w_rs1_hit  = id_use_rs1 & (id_rs1 == ex_rd);
    assign w_rs2_hit  = id_use_rs2 & (id_rs2 == ex_rd);
    assign w_load_use = ex_is_load & (ex_rd != 5'd0) & (w_rs1_hit | w_rs2_hit);
    assign w_lu_act   = w_load_use & ~ex_branch_taken;
    assign w_lost     = w_freeze | w_lu_act;

    assign stall_pc = w_freeze | w_lu_act;
    assign stall_d  = w_freeze | w_lu_act;
    assign stall_e  = w_freeze;
    assign stall_m  = w_freeze;
    assign stall_w  = w_freeze;
    assign flush_d  = ~w_freeze & ex_branch_taken;
    assign flush_e  = ~w_freeze & (ex_branch_taken | w_load_use);
    assign div_done = w_div_done;

    // ------------------------------------------------------------------
    // Lost-cycle counter and hang watchdog
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (w_lost && !(&r_stall_cycles)) begin
            r_stall_cycles <= r_stall_cycles + c_CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wd   <= '0;
            r_hang <= 1'b0;
        end else begin
            if (!w_freeze) begin
                r_wd <= '0;
            end else if (r_wd != c_WD_MAX) begin
                r_wd <= r_wd + c_WD_ONE;
            end
            if (w_freeze && (r_wd == c_WD_LAST)) begin
                r_hang <= 1'b1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign hang_err     = r_hang;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Brief    : Scoreboard bench for pipe_hazard_ctrl with directed vectors.
//  Revision : 1.0
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int c_TIMEOUT = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        icache_stall, dcache_stall, ex_div_valid, ex_is_load;
    logic [4:0]  ex_rd, id_rs1, id_rs2;
    logic        id_use_rs1, id_use_rs2, ex_branch_taken;
    logic        stall_pc, stall_d, stall_e, stall_m, stall_w;
    logic        flush_d, flush_e, div_done, hang_err;
    logic [31:0] stall_cycles;

    pipe_hazard_ctrl #(.DIV_LAT(32), .TIMEOUT(c_TIMEOUT), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .icache_stall(icache_stall), .dcache_stall(dcache_stall),
        .ex_div_valid(ex_div_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_branch_taken(ex_branch_taken),
        .stall_pc(stall_pc), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .stall_w(stall_w), .flush_d(flush_d), .flush_e(flush_e), .div_done(div_done),
        .stall_cycles(stall_cycles), .hang_err(hang_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  bits;   // {pc,d,e,m,w,flush_d,flush_e,div_done}
        logic        hang;
        logic [31:0] cnt;
        string       name;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          exp_cnt  = 0;
    int          exp_wd   = 0;
    logic        exp_hang = 1'b0;

    localparam logic [7:0] c_IDLE   = 8'b00000_00_0;
    localparam logic [7:0] c_FRZ    = 8'b11111_00_0;
    localparam logic [7:0] c_DONE   = 8'b00000_00_1;
    localparam logic [7:0] c_FRZDN  = 8'b11111_00_1;
    localparam logic [7:0] c_LU     = 8'b11000_01_0;
    localparam logic [7:0] c_BR     = 8'b00000_11_0;

    // Drive one cycle of inputs and queue the hand-derived response.
    task automatic step(input logic r, input logic ic, input logic dc, input logic dv,
                        input logic ld, input logic [4:0] rd, input logic [4:0] r1,
                        input logic [4:0] r2, input logic u1, input logic u2,
                        input logic br, input logic [7:0] eb, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; icache_stall = ic; dcache_stall = dc; ex_div_valid = dv;
        ex_is_load = ld; ex_rd = rd; id_rs1 = r1; id_rs2 = r2;
        id_use_rs1 = u1; id_use_rs2 = u2; ex_branch_taken = br;
        if (r) begin
            exp_cnt = 0; exp_wd = 0; exp_hang = 1'b0;
        end else begin
            exp_hang = exp_hang | (exp_wd >= c_TIMEOUT);
        end
        e.bits = eb; e.hang = exp_hang; e.cnt = exp_cnt; e.name = nm;
        q.push_back(e);
        if (!r) begin
            if (eb[7]) exp_cnt++;
            exp_wd = eb[5] ? exp_wd + 1 : 0;
        end
    endtask

    task automatic idle(input logic [7:0] eb, input string nm);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, eb, nm);
    endtask

    // Monitor: compare every queued expectation away from the active edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [7:0] act;
            e   = q.pop_front();
            act = {stall_pc, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e, div_done};
            n_checks++;
            if (act === e.bits && hang_err === e.hang && stall_cycles === e.cnt) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got bits=%b hang=%b cnt=%0d, expected bits=%b hang=%b cnt=%0d",
                         e.name, act, hang_err, stall_cycles, e.bits, e.hang, e.cnt);
            end
        end
    end

    initial begin
        #200000;
        n_checks++;
        $display("FAIL sim_timeout: got no completion, expected finish before 200000 ns");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        rst = 1'b1; icache_stall = 0; dcache_stall = 0; ex_div_valid = 0; ex_is_load = 0;
        ex_rd = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; ex_branch_taken = 0;

        step(1'b1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, c_IDLE, "reset");
        idle(c_IDLE, "post_reset_idle");

        // Plain divide: frozen 32 cycles, done on the 33rd, then back in RUN.
        for (int k = 0; k < 32; k++)
            step(1'b0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, c_FRZ, "div_freeze");
        step(1'b0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, c_DONE, "div_done");
        idle(c_IDLE, "div_back_run");

        // Divide whose done cycle collides with a 5-cycle D$ miss.
        for (int k = 0; k < 32; k++)
            step(1'b0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, c_FRZ, "div2_freeze");
        for (int k = 0; k < 5; k++)
            step(1'b0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, c_FRZDN, "div2_done_dstall");
        step(1'b0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, c_DONE, "div2_done_release");
        idle(c_IDLE, "div2_back_run");
        @(negedge clk);
        #1;
        n_checks++;
        if (stall_cycles === 32'd69) n_pass++;
        else $display("FAIL div2_stall_total: got %0d, expected 69", stall_cycles);

        // Load-use hazards.
        step(1'b0, 0, 0, 0, 1, 5'd5, 5'd0, 5'd5, 0, 1, 0, c_LU, "lu_rs2");
        step(1'b0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1, 0, c_IDLE, "lu_rd_zero");
        step(1'b0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd3, 0, 1, 0, c_IDLE, "lu_rs1_unused");
        step(1'b0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd3, 1, 0, 0, c_LU, "lu_rs1");
        step(1'b0, 0, 0, 0, 0, 5'd7, 5'd7, 5'd7, 1, 1, 0, c_IDLE, "no_load");

        // Branch vs load-use vs freeze priority.
        step(1'b0, 0, 0, 0, 1, 5'd5, 5'd0, 5'd5, 0, 1, 1, c_BR, "branch_over_lu");
        step(1'b0, 1, 0, 0, 1, 5'd5, 5'd0, 5'd5, 0, 1, 1, c_FRZ, "freeze_over_branch");
        step(1'b0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, c_FRZ, "icache_only");
        idle(c_IDLE, "pre_watchdog_idle");

        // Watchdog: 1024 frozen cycles, then sticky error.
        for (int k = 0; k < c_TIMEOUT; k++)
            step(1'b0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, c_FRZ, "wd_freeze");
        for (int k = 0; k < 3; k++)
            idle(c_IDLE, "wd_sticky");

        // Reset clears the error; then async reset in the middle of a divide.
        step(1'b1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, c_IDLE, "rst_clear_hang");
        for (int k = 0; k < 22; k++)
            step(1'b0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, c_FRZ, "div3_freeze");
        step(1'b1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, c_IDLE, "rst_mid_div");
        idle(c_IDLE, "after_rst_run");
        idle(c_IDLE, "after_rst_no_done");

        @(negedge clk);
        #1;
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL queue_drain: got %0d entries left, expected 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
